// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings and constants for the multDiv arbiter
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic        MODE_MULTU = 1'b0;
  localparam logic        MODE_DIVU  = 1'b1;
  localparam logic [31:0] DIV0_QUOT  = 32'hFFFF_FFFF;
  localparam int          MD_LATENCY = 34;

endpackage

// File: rtl/muldiv_arbiter_if.sv
// rtl/muldiv_arbiter_if.sv - requester side and multDiv side signal bundle
interface muldiv_arbiter_if #(
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    mode;
  logic [32*N_REQ-1:0] in_a;
  logic [32*N_REQ-1:0] in_b;
  logic [N_REQ-1:0]    done;
  logic [63:0]         result;
  logic                busy;
  logic                md_valid;
  logic                md_mode;
  logic [31:0]         md_a;
  logic [31:0]         md_b;
  logic                md_ready;
  logic [63:0]         md_out;

  modport slave (
    input  req, mode, in_a, in_b, md_ready, md_out,
    output done, result, busy, md_valid, md_mode, md_a, md_b
  );

  modport master (
    output req, mode, in_a, in_b, md_ready, md_out,
    input  done, result, busy, md_valid, md_mode, md_a, md_b
  );
endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first req at or above ptr, with wrap
module rr_pick #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W:0] cand;
  logic           found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int off = 0; off < N_REQ; off++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(off);
      if (cand >= (IDX_W+1)'(N_REQ)) cand = cand - (IDX_W+1)'(N_REQ);
      for (int i = 0; i < N_REQ; i++) begin
        if (!found && req[i] && (cand == (IDX_W+1)'(i))) begin
          found    = 1'b1;
          grant[i] = 1'b1;
          idx      = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/muldiv_arbiter.sv
// rtl/muldiv_arbiter.sv - shares one iterative multu/divu unit between N_REQ requesters
module muldiv_arbiter
  import muldiv_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  muldiv_arbiter_if.slave  bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic [63:0]        result_q, result_d;
  logic               busy_q, busy_d;
  logic               md_valid_q, md_valid_d;
  logic               md_mode_q, md_mode_d;
  logic [31:0]        md_a_q, md_a_d;
  logic [31:0]        md_b_q, md_b_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic [N_REQ-1:0]   gnt_oh_q, gnt_oh_d;

  logic [N_REQ-1:0]   pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic [31:0]        a_sel, b_sel;
  logic               mode_sel;

  rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .grant (pick_oh),
    .idx   (pick_idx)
  );

  always_comb begin
    a_sel    = '0;
    b_sel    = '0;
    mode_sel = MODE_MULTU;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        a_sel    = bus.in_a[i*32 +: 32];
        b_sel    = bus.in_b[i*32 +: 32];
        mode_sel = bus.mode[i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    done_d     = '0;
    result_d   = result_q;
    md_valid_d = 1'b0;
    md_mode_d  = md_mode_q;
    md_a_d     = md_a_q;
    md_b_d     = md_b_q;
    ptr_d      = ptr_q;
    gnt_idx_d  = gnt_idx_q;
    gnt_oh_d   = gnt_oh_q;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          gnt_idx_d = pick_idx;
          gnt_oh_d  = pick_oh;
          // Divide-by-zero is answered here so the unit stays free.
          if (mode_sel == MODE_DIVU && b_sel == 32'd0) begin
            result_d = {a_sel, DIV0_QUOT};
            done_d   = pick_oh;
            state_d  = RESP;
          end else begin
            md_valid_d = 1'b1;
            md_mode_d  = mode_sel;
            md_a_d     = a_sel;
            md_b_d     = b_sel;
            state_d    = ISSUE;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (bus.md_ready) begin
          result_d = bus.md_out;
          done_d   = gnt_oh_q;
          state_d  = RESP;
        end
      end
      RESP: begin
        ptr_d   = (gnt_idx_q == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      done_q     <= '0;
      result_q   <= '0;
      busy_q     <= 1'b0;
      md_valid_q <= 1'b0;
      md_mode_q  <= MODE_MULTU;
      md_a_q     <= '0;
      md_b_q     <= '0;
      ptr_q      <= '0;
      gnt_idx_q  <= '0;
      gnt_oh_q   <= '0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      result_q   <= result_d;
      busy_q     <= busy_d;
      md_valid_q <= md_valid_d;
      md_mode_q  <= md_mode_d;
      md_a_q     <= md_a_d;
      md_b_q     <= md_b_d;
      ptr_q      <= ptr_d;
      gnt_idx_q  <= gnt_idx_d;
      gnt_oh_q   <= gnt_oh_d;
    end
  end

  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.busy     = busy_q;
  assign bus.md_valid = md_valid_q;
  assign bus.md_mode  = md_mode_q;
  assign bus.md_a     = md_a_q;
  assign bus.md_b     = md_b_q;

endmodule
